// File: rtl/layer_eval_seq_if.sv
// Handshake and data bundle for one arithmetic-circuit layer evaluator.
// The master starts a run and supplies the previous layer's values; the slave
// (the evaluator) returns the gate results with ready/done status.
interface layer_eval_seq_if #(
  parameter int nbits   = 8,
  parameter int ninputs = 8,
  parameter int ngates  = 8
);
  logic                      en;
  logic [nbits*ninputs-1:0]  v_in;
  logic [nbits*ngates-1:0]   v_out;
  logic                      ready;
  logic                      done;

  modport master (
    output en,
    output v_in,
    input  v_out,
    input  ready,
    input  done
  );

  modport slave (
    input  en,
    input  v_in,
    output v_out,
    output ready,
    output done
  );
endinterface

// File: rtl/layer_eval_seq.sv
// Sequential evaluator for one arithmetic-circuit layer over GF(prime).
// A start pulse captures the previous layer's values (reduced mod prime), then
// nlanes gates are evaluated per cycle until all ngates results are registered.
module layer_eval_seq #(
  parameter int ngates  = 8,
  parameter int ninputs = 8,
  parameter int nbits   = 8,
  parameter int prime   = 251,
  parameter int nlanes  = 1,
  parameter int ninbits = $clog2(ninputs),
  parameter logic [2*ngates-1:0]       gates_fn  = '0,
  parameter logic [ninbits*ngates-1:0] gates_in0 = '0,
  parameter logic [ninbits*ngates-1:0] gates_in1 = '0
) (
  input logic clk,
  input logic rst,
  layer_eval_seq_if.slave bus
);

  localparam int G  = ngates / nlanes;
  localparam int CW = (G > 1) ? $clog2(G) : 1;
  localparam int GW = (ngates > 1) ? $clog2(ngates) : 1;
  localparam logic [nbits-1:0]   P  = nbits'(prime);
  localparam logic [2*nbits-1:0] P2 = (2*nbits)'(prime);

  // Illegal configurations stop elaboration by instantiating a module that does not exist.
  if ((ngates % nlanes) != 0) begin : g_err_lanes
    layer_eval_seq_bad_nlanes u_bad_nlanes ();
  end
  if ((prime >= (2**nbits)) || (prime < 2)) begin : g_err_prime
    layer_eval_seq_bad_prime u_bad_prime ();
  end
  for (genvar gc = 0; gc < ngates; gc++) begin : g_chk
    if ((int'(gates_in0[gc*ninbits +: ninbits]) >= ninputs) ||
        (int'(gates_in1[gc*ninbits +: ninbits]) >= ninputs)) begin : g_err_idx
      layer_eval_seq_bad_index u_bad_index ();
    end
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic               w_last;
  logic [nbits-1:0]   r_cap  [ninputs];
  logic [nbits-1:0]   r_vout [ngates];
  logic [GW-1:0]      w_gidx [nlanes];
  logic [nbits-1:0]   w_res  [nlanes];
  logic [nbits*ngates-1:0] w_vout;

  function automatic logic [nbits-1:0] mod_reduce(input logic [nbits-1:0] x);
    return x % P;
  endfunction

  // Operands are already reduced, so add/sub need at most one correction step.
  function automatic logic [nbits-1:0] gate_eval(input logic [1:0] fn,
                                                 input logic [nbits-1:0] a,
                                                 input logic [nbits-1:0] b);
    logic [nbits:0]     s;
    logic [2*nbits-1:0] prod;
    case (fn)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, P}) ? nbits'(s - {1'b0, P}) : nbits'(s);
      end
      2'b01: begin
        prod = {{nbits{1'b0}}, a} * {{nbits{1'b0}}, b};
        return nbits'(prod % P2);
      end
      2'b10: return (a >= b) ? (a - b) : nbits'({1'b0, a} + {1'b0, P} - {1'b0, b});
      default: return a;
    endcase
  endfunction

  assign w_last = (r_cnt == CW'(G - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: start on en while idle, return to idle after the last group.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.en) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Group counter and one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_RUN) && w_last;
      if (r_state == S_IDLE) r_cnt <= '0;
      else                   r_cnt <= r_cnt + CW'(1);
    end
  end

  // Input capture on the accepted start edge; later v_in changes are ignored.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.en) begin
      for (int i = 0; i < ninputs; i++) r_cap[i] <= mod_reduce(bus.v_in[i*nbits +: nbits]);
    end
  end

  // Per-lane gate selection and evaluation for the current group.
  always_comb begin
    for (int k = 0; k < nlanes; k++) begin
      w_gidx[k] = GW'(int'(r_cnt) * nlanes + k);
      w_res[k]  = gate_eval(gates_fn[2*w_gidx[k] +: 2],
                            r_cap[gates_in0[w_gidx[k]*ninbits +: ninbits]],
                            r_cap[gates_in1[w_gidx[k]*ninbits +: ninbits]]);
    end
  end

  // Result registers: cleared by reset, one group written per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < ngates; g++) r_vout[g] <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < nlanes; k++) r_vout[w_gidx[k]] <= w_res[k];
    end
  end

  // Flatten results onto the output bus.
  always_comb begin
    w_vout = '0;
    for (int g = 0; g < ngates; g++) w_vout[g*nbits +: nbits] = r_vout[g];
  end

  assign bus.v_out = w_vout;
  assign bus.ready = (r_state == S_IDLE);
  assign bus.done  = r_done;

endmodule
